aes_inv_cipher_iter: RTL and testbench
======================================

# aes_inv_cipher_iter

Iterative AES inverse cipher: accepts one 128-bit ciphertext block over a valid/ready handshake and performs one inverse round per clock. It returns the plaintext over a second valid/ready handshake. It is the decrypt-side streaming engine that pairs with the encrypt path. It consumes the round-key bus produced by a `KeyExpansion #(Nk,Nr)` instance with the same parameters, and one instance is built per key size (10/12/14 rounds).

## Interface
- `Nk`, default 4: key length in 32-bit words (4/6/8).
- `Nr`, default 10: number of rounds (10/12/14); must match `Nk`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: reset is synchronous and active-low. It is asserted when 0 and sampled on the `clk` rising edge.
- `in_valid` input 1: ciphertext offered.
- `in_ready` output 1: block can accept a ciphertext this cycle.
- `ciphertext` input 128: input block, byte 0 at bits [127:120].
- `words` input 128*(Nr+1): expanded key schedule.
  - Round key r is `words[128*(Nr+1)-1-128*r -: 128]`, so round key 0 occupies the MSBs.
- `out_valid` output 1: plaintext available.
- `out_ready` input 1: downstream consumes plaintext.
- `plaintext` output 128: result block, held stable while `out_valid`.
- `busy` output 1: a block is in flight, in state ROUND or FINAL.

## Operation
- **State machine:** IDLE, ROUND, FINAL, DONE. A 4-bit round counter `rnd` and a 128-bit state register `st` hold the working data.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: `st` <= `ciphertext` ^ rk[Nr] and `rnd` <= Nr-1, then go to ROUND.
- **ROUND:**
  - `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ rk[`rnd`]) and `rnd` <= `rnd`-1.
  - When `rnd`==1, go to FINAL.
- **FINAL:**
  - `plaintext` <= InvSubBytes(InvShiftRows(`st`)) ^ rk[0].
  - `out_valid` <= 1, then go to DONE.
- **DONE:**
  - `out_valid`=1 and `plaintext` is held.
  - `out_ready`=1 with `in_valid`=0: clear `out_valid` and go to IDLE.
  - `out_ready`=1 with `in_valid`=1: consume the output and accept the new block on the same edge. The new block's initial AddRoundKey is loaded and the FSM goes to ROUND.
- **in_ready:** `in_ready` = reset & (IDLE | (DONE & `out_ready`)). It is 0 in ROUND and FINAL, and `in_valid` there is ignored.
- **Key bus stability:** `words` is read live every round. It must be stable from the accept edge until `out_valid` rises; changing it earlier gives undefined output.
- **Round primitives:** InvShiftRows, InvSubBytes (inverse S-box) and InvMixColumns are the existing codebase primitives, instantiated combinationally. There is one instance of each, shared across rounds.
- **Reset mid-operation:** any in-flight block is discarded with no output produced. `out_valid` drops on that edge.
- **Reset values:**
  - state IDLE, `rnd`=0, `st`=0.
  - `plaintext`=0, `out_valid`=0, `busy`=0.
  - `in_ready`=0 while `reset`=0.

## Timing
- **Accept edge:** the edge where `in_valid` & `in_ready` are both high is called edge 0.
- **Round edges:** edges 1..Nr-1 perform ROUND and edge Nr performs FINAL.
- **Output:** `out_valid` is high after edge Nr. Latency is Nr cycles (10/12/14).
- **Back-to-back throughput:** one block per Nr+1 cycles when `out_ready` is held high.
- **Output hold:** `plaintext` and `out_valid` change only on the DONE exit edge or on reset. There is no combinational path from `out_ready` to `plaintext`.
- **`busy`:** high from the edge after accept through edge Nr inclusive.

## Configuration
- **Macro `AES_INV_EQUAL_EN`:**
  - Adds input `expected` (128 bits) and output `equal` (1 bit).
  - `equal` is registered on the FINAL edge as (result == `expected`) and held through DONE.
  - `equal` clears to 0 on reset or on DONE exit.
- **Without the macro:** both ports and the comparator are absent, and behaviour is otherwise identical.

## Test plan
- **AES-128:** Nk=4/Nr=10, key 000102030405060708090a0b0c0d0e0f via KeyExpansion, `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a -> `plaintext` 00112233445566778899aabbccddeeff, with `out_valid` exactly 10 cycles after accept.
- **AES-192:** Nk=6/Nr=12, key 000102…1617, `ciphertext` dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, with latency 12.
- **AES-256:** Nk=8/Nr=14, key 000102…1e1f, `ciphertext` 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, with latency 14.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` -> `plaintext` stable, `in_ready`=0, and a second `in_valid` is not accepted. Then pulse `out_ready` with `in_valid`=1 -> second block accepted on that edge and its result arrives Nr cycles later.
- **Reset mid-operation:** drive `reset`=0 at round 5 -> next cycle `busy`=0, `out_valid`=0, `plaintext`=0. A fresh block after release decrypts correctly.
- **AES_INV_EQUAL_EN:** with `expected`=00112233445566778899aabbccddeeff -> `equal`=1 in DONE. With `expected`=0 -> `equal`=0.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, valid/ready in and out.
// Optional AES_INV_EQUAL_EN adds an `expected` input and a registered `equal` flag.
module aes_inv_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [127:0]            ciphertext,
   input  logic [128*(Nr+1)-1:0]   words,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            plaintext,
`ifdef AES_INV_EQUAL_EN
   input  logic [127:0]            expected,
   output logic                    equal,
`endif
   output logic                    busy
);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

   // First round index after the initial AddRoundKey (Nr-1 for a matched Nk/Nr pair).
   localparam logic [3:0] RND_LAST = 4'(Nk + 5);

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++)
         o[127-8*k -: 8] = INV_SBOX[2047-8*int'(s[127-8*k -: 8]) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      logic [7:0]   x2 [4];
      logic [7:0]   x4 [4];
      logic [7:0]   x8 [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = s[127-8*(4*c+r) -: 8];
            x2[r] = xt(a[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
         end
         o[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return o;
   endfunction

   state_t        state_q;
   logic [3:0]    rnd_q;
   logic [127:0]  st_q;
   logic [127:0]  plaintext_q;
   logic          out_valid_q;
`ifdef AES_INV_EQUAL_EN
   logic          equal_q;
`endif

   logic [127:0]  rk_s [0:Nr];
   logic [127:0]  isr_s;
   logic [127:0]  isb_s;
   logic [127:0]  ark_s;
   logic [127:0]  imc_s;

   for (genvar r = 0; r <= Nr; r++) begin : g_rk
      assign rk_s[r] = words[128*(Nr+1)-1-128*r -: 128];
   end

   // Shared datapath; in FINAL rnd_q has reached 0 so ark_s already uses round key 0.
   assign isr_s = inv_shift_rows(st_q);
   assign isb_s = inv_sub_bytes(isr_s);
   assign ark_s = isb_s ^ rk_s[rnd_q];
   assign imc_s = inv_mix_columns(ark_s);

   assign in_ready  = reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign busy      = (state_q == S_ROUND) | (state_q == S_FINAL);
   assign out_valid = out_valid_q;
   assign plaintext = plaintext_q;
`ifdef AES_INV_EQUAL_EN
   assign equal     = equal_q;
`endif

   // Control FSM together with the round state and the registered result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rnd_q       <= 4'd0;
         st_q        <= 128'h0;
         plaintext_q <= 128'h0;
         out_valid_q <= 1'b0;
`ifdef AES_INV_EQUAL_EN
         equal_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  st_q    <= ciphertext ^ rk_s[Nr];
                  rnd_q   <= RND_LAST;
                  state_q <= S_ROUND;
               end
            end
            S_ROUND: begin
               st_q  <= imc_s;
               rnd_q <= rnd_q - 4'd1;
               if (rnd_q == 4'd1) begin
                  state_q <= S_FINAL;
               end
            end
            S_FINAL: begin
               plaintext_q <= ark_s;
               out_valid_q <= 1'b1;
`ifdef AES_INV_EQUAL_EN
               equal_q     <= (ark_s == expected);
`endif
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
`ifdef AES_INV_EQUAL_EN
                  equal_q     <= 1'b0;
`endif
                  if (in_valid) begin
                     st_q    <= ciphertext ^ rk_s[Nr];
                     rnd_q   <= RND_LAST;
                     state_q <= S_ROUND;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: AES-128/192/256 instances with FIPS-197 vectors.
// Key schedules come from an independent key expansion built on an algorithmic S-box.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

   logic clk;
   logic reset;
   logic [2:0]    iv_v;
   logic [2:0]    ordy_v;
   logic [2:0]    ir_v;
   logic [2:0]    ov_v;
   logic [2:0]    busy_v;
   logic [127:0]  ct_v  [3];
   logic [127:0]  pt_v  [3];
   logic [127:0]  exp_v [3];
   logic [2:0]    eq_v;
   logic [1407:0] words128;
   logic [1663:0] words192;
   logic [1919:0] words256;
   logic [127:0]  ct_ref [3];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   aes_inv_cipher_iter #(.Nk(4), .Nr(10)) d128 (
      .clk(clk), .reset(reset), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
      .ciphertext(ct_v[0]), .words(words128), .out_valid(ov_v[0]), .out_ready(ordy_v[0]),
      .plaintext(pt_v[0]),
`ifdef AES_INV_EQUAL_EN
      .expected(exp_v[0]), .equal(eq_v[0]),
`endif
      .busy(busy_v[0]));

   aes_inv_cipher_iter #(.Nk(6), .Nr(12)) d192 (
      .clk(clk), .reset(reset), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
      .ciphertext(ct_v[1]), .words(words192), .out_valid(ov_v[1]), .out_ready(ordy_v[1]),
      .plaintext(pt_v[1]),
`ifdef AES_INV_EQUAL_EN
      .expected(exp_v[1]), .equal(eq_v[1]),
`endif
      .busy(busy_v[1]));

   aes_inv_cipher_iter #(.Nk(8), .Nr(14)) d256 (
      .clk(clk), .reset(reset), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
      .ciphertext(ct_v[2]), .words(words256), .out_valid(ov_v[2]), .out_ready(ordy_v[2]),
      .plaintext(pt_v[2]),
`ifdef AES_INV_EQUAL_EN
      .expected(exp_v[2]), .equal(eq_v[2]),
`endif
      .busy(busy_v[2]));

`ifndef AES_INV_EQUAL_EN
   assign eq_v = 3'b000;
`endif

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // ---------------- reference key expansion ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gm(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      int total;
      total = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      r = '0;
      for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
      return r;
   endfunction

   // ---------------- transaction helpers ----------------
   task automatic start_block(input int i, input logic [127:0] ct, input string tag);
      int cyc;
      iv_v[i] = 1'b1;
      ct_v[i] = ct;
      cyc = 0;
      while (ir_v[i] !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, " in_ready before accept"}, 128'(ir_v[i]), 128'h1);
      @(posedge clk); #1;
      iv_v[i] = 1'b0;
      check_eq({tag, " busy after accept"}, 128'(busy_v[i]), 128'h1);
   endtask

   task automatic wait_done(input int i, input int nr, input logic [127:0] want, input string tag);
      int cyc;
      cyc = 0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (ov_v[i] === 1'b1) break;
      end
      check_eq({tag, " latency"}, 128'(cyc), 128'(nr));
      check_eq({tag, " plaintext"}, pt_v[i], want);
      check_eq({tag, " busy in DONE"}, 128'(busy_v[i]), 128'h0);
   endtask

   task automatic consume(input int i, input string tag);
      ordy_v[i] = 1'b1;
      @(posedge clk); #1;
      ordy_v[i] = 1'b0;
      check_eq({tag, " out_valid after consume"}, 128'(ov_v[i]), 128'h0);
      check_eq({tag, " equal after consume"}, 128'(eq_v[i]), 128'h0);
      check_eq({tag, " in_ready in IDLE"}, 128'(ir_v[i]), 128'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b0;
      iv_v   = 3'b000;
      ordy_v = 3'b000;
      ct_ref[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      ct_ref[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      ct_ref[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
      for (int i = 0; i < 3; i++) begin
         ct_v[i]  = 128'h0;
         exp_v[i] = PT;
      end
      build_sbox();
      check_eq("sbox[00]", 128'(sbox_t[0]), 128'h63);
      begin
         logic [1919:0] full;
         full = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
         words128 = full[1919 -: 1408];
         full = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
         words192 = full[1919 -: 1664];
         words256 = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      end

      repeat (3) @(posedge clk);
      #1;
      check_eq("reset in_ready", 128'(ir_v), 128'h0);
      check_eq("reset out_valid", 128'(ov_v), 128'h0);
      check_eq("reset busy", 128'(busy_v), 128'h0);
      check_eq("reset plaintext", pt_v[0], 128'h0);
      check_eq("reset equal", 128'(eq_v), 128'h0);
      reset = 1'b1;
      #1;
      check_eq("in_ready after release", 128'(ir_v), 128'h7);

      // One block per key size.
      for (int i = 0; i < 3; i++) begin
         start_block(i, ct_ref[i], $sformatf("aes%0d", 128 + 64*i));
         wait_done(i, 10 + 2*i, PT, $sformatf("aes%0d", 128 + 64*i));
`ifdef AES_INV_EQUAL_EN
         check_eq($sformatf("aes%0d equal", 128 + 64*i), 128'(eq_v[i]), 128'h1);
`endif
         consume(i, $sformatf("aes%0d", 128 + 64*i));
      end

      // Backpressure: result held, second block refused until out_ready.
      start_block(0, ct_ref[0], "bp first");
      wait_done(0, 10, PT, "bp first");
      iv_v[0] = 1'b1;
      ct_v[0] = ct_ref[0];
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("bp hold%0d plaintext", k), pt_v[0], PT);
         check_eq($sformatf("bp hold%0d out_valid", k), 128'(ov_v[0]), 128'h1);
         check_eq($sformatf("bp hold%0d in_ready", k), 128'(ir_v[0]), 128'h0);
         check_eq($sformatf("bp hold%0d busy", k), 128'(busy_v[0]), 128'h0);
      end
      ordy_v[0] = 1'b1;
      #1;
      check_eq("bp in_ready with out_ready", 128'(ir_v[0]), 128'h1);
      @(posedge clk); #1;
      ordy_v[0] = 1'b0;
      iv_v[0]   = 1'b0;
      check_eq("bp second accepted busy", 128'(busy_v[0]), 128'h1);
      check_eq("bp out_valid dropped", 128'(ov_v[0]), 128'h0);
      check_eq("bp in_ready while busy", 128'(ir_v[0]), 128'h0);
      wait_done(0, 10, PT, "bp second");
      consume(0, "bp second");

`ifdef AES_INV_EQUAL_EN
      // Comparator miss.
      exp_v[0] = 128'h0;
      start_block(0, ct_ref[0], "eq miss");
      wait_done(0, 10, PT, "eq miss");
      check_eq("eq miss equal", 128'(eq_v[0]), 128'h0);
      consume(0, "eq miss");
      exp_v[0] = PT;
`endif

      // Reset in the middle of a block, then a fresh block.
      start_block(0, ct_ref[0], "rst mid");
      iv_v[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst mid in_valid ignored busy", 128'(busy_v[0]), 128'h1);
      iv_v[0] = 1'b0;
      reset = 1'b0;
      #1;
      check_eq("rst mid in_ready low", 128'(ir_v[0]), 128'h0);
      @(posedge clk); #1;
      check_eq("rst mid busy", 128'(busy_v[0]), 128'h0);
      check_eq("rst mid out_valid", 128'(ov_v[0]), 128'h0);
      check_eq("rst mid plaintext", pt_v[0], 128'h0);
      reset = 1'b1;
      #1;
      start_block(0, ct_ref[0], "after rst");
      wait_done(0, 10, PT, "after rst");
      consume(0, "after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
